// File: rtl/arm_dmem_mmio_if.sv
// Core data-port bus between the single-cycle ARM core and its data-side responder.
// The core drives address, strobe and store data; the responder returns load data in the same cycle.
interface arm_dmem_mmio_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
    modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);
endinterface

// File: rtl/arm_dmem_mmio.sv
// Data-side responder: word RAM plus an MMIO page with a cycle counter, an LED register
// and a byte TX FIFO drained by a valid/ready consumer. Loads are combinational.
module arm_dmem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    arm_dmem_mmio_if.slave     bus,
    output logic [31:0]        leds,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [29:0] CYCLE_WORD  = 30'h3FFF_C000;
    localparam logic [29:0] LEDS_WORD   = 30'h3FFF_C001;
    localparam logic [29:0] TXDATA_WORD = 30'h3FFF_C002;
    localparam logic [29:0] STATUS_WORD = 30'h3FFF_C003;

    logic [29:0] word;
    logic        ram_hit, cycle_hit, leds_hit, tx_hit, status_hit;
    logic        unused_adr_lsbs;

    assign word            = bus.DataAdr[31:2];
    assign unused_adr_lsbs = &{1'b0, bus.DataAdr[1:0]};
    // RAM occupies only the bottom of the map; everything above its range must decode as a miss.
    assign ram_hit    = (bus.DataAdr[31:AW+2] == '0);
    assign cycle_hit  = (word == CYCLE_WORD);
    assign leds_hit   = (word == LEDS_WORD);
    assign tx_hit     = (word == TXDATA_WORD);
    assign status_hit = (word == STATUS_WORD);

    logic [31:0] ram [RAM_WORDS];

    // NOTE: storage arrays get no reset branch, so they map onto RAM primitives and keep contents across reset.
    always_ff @(posedge clk) begin
        if (bus.MemWrite && ram_hit) ram[bus.DataAdr[AW+1:2]] <= bus.WriteData;
    end

    logic [31:0] cycle_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            leds      <= '0;
        end else begin
            if (bus.MemWrite && cycle_hit) cycle_cnt <= bus.WriteData;
            else                           cycle_cnt <= cycle_cnt + 32'd1;
            if (bus.MemWrite && leds_hit)  leds <= bus.WriteData;
        end
    end

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [3:0]    count;
    logic          overflow;
    logic          full, push, pop, push_ok;

    assign full     = (count == 4'(FIFO_DEPTH));
    assign tx_valid = (count != 4'd0);
    assign pop      = tx_valid & tx_ready;
    assign push     = bus.MemWrite & tx_hit;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push & (~full | pop);
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= bus.WriteData[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (push && full && !pop)             overflow <= 1'b1;
            else if (bus.MemWrite && status_hit)  overflow <= 1'b0;
        end
    end

    logic [31:0] rdata;

    // NOTE: the read mux assigns a default first so no path through always_comb can infer a latch.
    always_comb begin
        rdata = '0;
        if (ram_hit)         rdata = ram[bus.DataAdr[AW+1:2]];
        else if (cycle_hit)  rdata = cycle_cnt;
        else if (leds_hit)   rdata = leds;
        else if (status_hit) rdata = {24'h0, count, 1'b0, overflow, ~tx_valid, full};
    end

    assign bus.ReadData = rdata;

endmodule
